// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// default bus widths and the wait-state counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int WC_W   = 4;

  // Counter preload so that the WAIT state lasts exactly wc cycles.
  function automatic logic [WC_W-1:0] wait_load(input int wc);
    return (wc > 0) ? WC_W'(wc - 1) : '0;
  endfunction

endpackage

// File: rtl/mem_word_store.sv
// Single-port synchronous word storage with a registered read port.
// A write also loads the read register with the written word (write-through).
module mem_word_store #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DW-1:0]         wdata,
  output logic [DW-1:0]         rdata
);

  logic [DW-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];
  logic [DW-1:0] rdata_r;

  // Storage array update; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: written word on a write, stored word on a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (en) begin
      rdata_r <= we ? wdata : mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, WAIT_CYC wait states, then
// a single access cycle and a valid/ready response. Optional range checking
// is enabled by defining MEM_RESPONDER_ADDR_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int DEPTH_LOG2 = 8,
  parameter int WAIT_CYC   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  localparam logic [WC_W-1:0] WAIT_LOAD = wait_load(WAIT_CYC);

  state_t                state_r, state_s;
  logic [WC_W-1:0]       cnt_r, cnt_s;
  logic                  accept_s;
  logic                  we_r;
  logic [DEPTH_LOG2-1:0] idx_r;
  logic [DW-1:0]         wdata_r;
  logic                  store_en_s;
  logic                  store_we_s;
  logic [DW-1:0]         store_rdata_s;

  assign accept_s = req_valid && (state_r == ST_IDLE);

  // State, wait counter and request capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        we_r    <= req_we;
        idx_r   <= req_addr[DEPTH_LOG2-1:0];
        wdata_r <= req_wdata;
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_CYC > 0) begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_LOAD;
          end else begin
            state_s = ST_ACCESS;
            cnt_s   = '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == '0) begin
          state_s = ST_ACCESS;
        end else begin
          cnt_s = cnt_r - 1'b1;
        end
      end
      ST_ACCESS: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        req_ready = !rst;
        busy      = 1'b0;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign store_en_s = (state_r == ST_ACCESS);

`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  logic oor_r;

  // Out-of-range flag captured with the request and held for its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_r <= 1'b0;
    end else if (accept_s) begin
      oor_r <= |req_addr[AW-1:DEPTH_LOG2];
    end
  end

  assign store_we_s = we_r && !oor_r;
  assign rsp_rdata  = oor_r ? (we_r ? wdata_r : '0) : store_rdata_s;
  assign rsp_err    = oor_r;
`else
  logic addr_hi_unused_s;

  // Upper address bits alias onto the storage index.
  assign addr_hi_unused_s = |req_addr[AW-1:DEPTH_LOG2];
  assign store_we_s       = we_r;
  assign rsp_rdata        = store_rdata_s;
  assign rsp_err          = 1'b0;
`endif

  mem_word_store #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DW         (DW)
  ) u_store (
    .clk   (clk),
    .rst   (rst),
    .en    (store_en_s),
    .we    (store_we_s),
    .addr  (idx_r),
    .wdata (wdata_r),
    .rdata (store_rdata_s)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: one instance with two wait
// states and one with none, sharing request buses and selected by sel.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic [15:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [15:0] b_rsp_rdata;

  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [15:0] o_rsp_rdata;

  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

  always #5 clk = ~clk;

  mem_responder #(.AW(16), .DW(16), .DEPTH_LOG2(8), .WAIT_CYC(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  mem_responder #(.AW(16), .DW(16), .DEPTH_LOG2(8), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int total = 0;
  int bad = 0;
  logic [16:0] sb_q[$];
  logic [15:0] mdl [0:1][0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference memory: returns {err, rdata} for one request and updates state.
  function automatic logic [16:0] model_step(input bit b, input bit we,
                                             input logic [15:0] addr, input logic [15:0] wdata);
    logic [7:0] idx;
    logic       oor;
    idx = addr[7:0];
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
    oor = |addr[15:8];
`else
    oor = 1'b0;
`endif
    if (oor) return {1'b1, (we ? wdata : 16'h0000)};
    if (we) begin
      mdl[b][idx] = wdata;
      return {1'b0, wdata};
    end
    return {1'b0, mdl[b][idx]};
  endfunction

  task automatic check_rsp(input string tag);
    logic [16:0] exp;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      chk(tag, {15'd0, o_rsp_err, o_rsp_rdata}, {15'd0, exp});
    end
  endtask

  // One full transaction, entered and left on a falling edge.
  task automatic do_req(input bit b, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold, input string tag);
    int k;
    int w;
    w = b ? 0 : 2;
    sb_q.push_back(model_step(b, we, addr, wdata));
    sel = b; req_we = we; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    k = 0;
    while (!o_req_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_acc"}, o_req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_busy"}, o_busy, 1);
    k = 1;
    while (!o_rsp_valid && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, w + 2);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_v"}, o_rsp_valid, 1);
      chk({tag, "_hold_d"}, o_rsp_rdata, (sb_q.size() != 0) ? sb_q[0][15:0] : 16'h0000);
      chk({tag, "_hold_rdy"}, o_req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check_rsp(tag);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_idle_v"}, o_rsp_valid, 0);
    chk({tag, "_idle_rdy"}, o_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int rsp;
    int cyc;
    int last;
    int stale;

    // Reset state, sampled while rst is high and after it falls.
    repeat (3) @(negedge clk);
    chk("rst_rdy", a_req_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_data", a_rsp_rdata, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", a_req_ready, 1);
    chk("idle_busy", a_busy, 0);
    chk("idle_valid", a_rsp_valid, 0);
    chk("idle_data", a_rsp_rdata, 16'h0000);
    chk("idle_err", a_rsp_err, 0);

    // Write then read back with two wait states.
    do_req(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, "wr5");
    do_req(1'b0, 1'b0, 16'h0005, 16'h0000, 0, "rd5");

    // Zero wait states, response stalled for five cycles.
    do_req(1'b1, 1'b1, 16'h0010, 16'h5A3C, 0, "b_wr10");
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 5, "b_rd10");

    // Reset during the WAIT of a write abandons it.
    do_req(1'b0, 1'b1, 16'h0003, 16'h1234, 0, "wr3");
    sel = 1'b0; req_we = 1'b1; req_addr = 16'h0003; req_wdata = 16'hFFFF;
    req_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0;
    while (!o_req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy_rst", o_busy, 0);
    chk("abort_valid_rst", o_rsp_valid, 0);
    chk("abort_rdy_rst", o_req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin @(negedge clk); if (o_rsp_valid) stale++; end
    chk("abort_stale", stale, 0);
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 16'h0003, 16'h0000, 0, "rd3");

    // Upper address bits alias (or flag an error when range checking is on).
    do_req(1'b0, 1'b1, 16'h0002, 16'h1111, 0, "wr2");
    do_req(1'b0, 1'b1, 16'h0102, 16'hA5A5, 0, "wr102");
    do_req(1'b0, 1'b0, 16'h0002, 16'h0000, 0, "rd2");

    // req_valid held high across three back-to-back reads.
    for (int i = 0; i < 3; i++) sb_q.push_back(model_step(1'b0, 1'b0, 16'h0005, 16'h0000));
    sel = 1'b0; req_we = 1'b0; req_addr = 16'h0005;
    req_valid = 1'b1; rsp_ready = 1'b1;
    acc = 0; rsp = 0; cyc = 0; last = 0;
    while ((acc < 3 || rsp < 3) && cyc < 80) begin
      if (req_valid && o_req_ready) begin
        chk("held_idle_busy", o_busy, 0);
        if (acc > 0) chk("held_spacing", cyc - last, 5);
        last = cyc;
        acc++;
      end else begin
        chk("held_busy", o_busy, 1);
      end
      if (o_rsp_valid) begin
        check_rsp("held_rsp");
        rsp++;
      end
      @(negedge clk);
      cyc++;
      if (acc == 3) req_valid = 1'b0;
    end
    chk("held_accepts", acc, 3);
    chk("held_rsps", rsp, 3);
    repeat (8) @(negedge clk);
    chk("held_no_extra", o_rsp_valid, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's address register: the far end of the address/data path.
- Accepts one request per handshake (address, write-enable, write data) and models a memory with configurable wait states.
- Returns read data or a write acknowledgement through a valid/ready response channel.
- Sits between the CPU datapath (address/data registers) and on-chip word storage.

Parameters:
- AW, 16, address width in bits
- DW, 16, data word width in bits
- DEPTH_LOG2, 8, log2 of storage depth in words; index = req_addr[DEPTH_LOG2-1:0]
- WAIT_CYC, 2, wait-state cycles inserted before the access cycle; legal range 0..15

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request; high only in IDLE with rst low
- req_we  in  1  1 = write, 0 = read; sampled at accept
- req_addr  in  AW  word address; sampled at accept
- req_wdata  in  DW  write data; sampled at accept
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DW  read data (read) or echoed write data (write)
- rsp_err  out  1  address out of range (only with ADDR_CHECK_EN; tied 0 otherwise)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE; wait counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 0.
  - Storage contents are not reset.
- Reset mid-transaction: the transaction is abandoned. A write not yet in ACCESS never modifies storage. No response is issued.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid & req_ready: latch we/addr/wdata.
  - Go to WAIT with counter = WAIT_CYC-1 if WAIT_CYC > 0; otherwise go straight to ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS on the cycle the counter reads 0. The WAIT state lasts exactly WAIT_CYC cycles.
- ACCESS (exactly 1 cycle):
  - Write: storage[idx] <= wdata; rsp_rdata <= wdata.
  - Read: rsp_rdata <= storage[idx].
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE.
  - req_ready is 0 throughout RESP, so back-to-back requests take at least one IDLE cycle.
- Latency: accept edge at cycle 0 → rsp_valid high from cycle WAIT_CYC+2. With WAIT_CYC=0 this is cycle 2.
- At most one outstanding transaction. A req_valid held high while busy is ignored until IDLE.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Address wrap: upper address bits beyond DEPTH_LOG2 are ignored (aliasing) unless ADDR_CHECK_EN is defined.
- rsp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: MEM_RESPONDER_ADDR_CHECK_EN
- Defined:
  - Accept computes out-of-range = |req_addr[AW-1:DEPTH_LOG2]|.
  - Out-of-range write: storage is not modified.
  - Out-of-range read: returns rsp_rdata = 0.
  - In both cases rsp_err = 1 for that response. Timing is unchanged.
- Undefined: rsp_err is constant 0 and addresses alias.

Decomposition:
- Shared package mem_pkg:
  - FSM state typedef (IDLE/WAIT/ACCESS/RESP, 2-bit encoding).
  - Default widths AW_DEF = 16, DW_DEF = 16.
  - Wait-counter width constant WC_W = 4.
- One sub-module: mem_word_store. Single-port synchronous storage with write-enable, DEPTH_LOG2 / DW parameters, registered read. It is instantiated once and is driven only in ACCESS.

Test Plan:
- Reset then idle, WAIT_CYC=2 → req_ready=1 and busy=0 after rst falls; rsp_valid=0; rsp_rdata=16'h0000.
- Write addr 16'h0005 data 16'hBEEF, then read addr 16'h0005 with rsp_ready held high → read response rsp_rdata=16'hBEEF. Each rsp_valid rises exactly 4 cycles after its accept edge.
- WAIT_CYC=0, read addr 16'h0010 → rsp_valid 2 cycles after accept. Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0. Release → IDLE next cycle.
- Write 16'h1234 to 16'h0003, then assert rst during WAIT of a write 16'hFFFF to 16'h0003, then read 16'h0003 → 16'h1234 and no stale response after reset.
- Aliasing (no macro): write 16'hA5A5 to 16'h0102, read 16'h0002 → 16'hA5A5. With MEM_RESPONDER_ADDR_CHECK_EN: the same write gives rsp_err=1, and the read of 16'h0002 returns the prior contents with rsp_err=0.
- req_valid held high continuously for 3 requests → exactly 3 accepts, each only while in IDLE. busy is high from the accept edge through the response handshake.
